sw_sel_ctrl: RTL and testbench

SW_SEL_CTRL -- requirements
Module: sw_sel_ctrl

---
 rtl/sw_sel_pkg.sv | 33 +++
 rtl/sw_sel_hold_timer.sv | 39 +++
 rtl/sw_sel_ctrl.sv | 137 +++++++++++++
 tb/tb_sw_sel_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_sel_pkg.sv
// sw_sel_pkg: shared types and constants for the serial switch-select controller.
//   SEL_W / ERR_CNT_W  : output code and error counter widths
//   FRAME_BITS         : bits per frame including start bit (depends on SW_SEL_PARITY_EN)
//   state_e            : controller FSM state encoding
package sw_sel_pkg;

  localparam int unsigned SEL_W            = 3;
  localparam int unsigned ERR_CNT_W        = 4;
  localparam int unsigned DATA_BITS        = 3;
  localparam int unsigned BIT_CNT_W        = 2;
  localparam int unsigned HOLD_CNT_W       = 4;
  localparam int unsigned FRAME_BITS_PAR   = 5;  // start + 3 data + parity
  localparam int unsigned FRAME_BITS_NOPAR = 4;  // start + 3 data

`ifdef SW_SEL_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // True when data code plus parity bit carry an even number of ones.
  function automatic logic parity_even(input logic [SEL_W-1:0] code, input logic par);
    return ~((^code) ^ par);
  endfunction

endpackage

// File: rtl/sw_sel_hold_timer.sv
// sw_sel_hold_timer: post-accept dwell counter.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : reload the counter with HOLD_CYCLES
//   done_c      : high during the last dwell cycle (counter == 1)
module sw_sel_hold_timer
  import sw_sel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_c
);

  logic [HOLD_CNT_W-1:0] cnt_q;
  logic [HOLD_CNT_W-1:0] cnt_d;

  // Load on accept, then count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = HOLD_CNT_W'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == HOLD_CNT_W'(1));

endmodule

// File: rtl/sw_sel_ctrl.sv
// sw_sel_ctrl: decodes serial frames on x into a registered switch-select code.
// Optional parity checking is enabled by defining SW_SEL_PARITY_EN.
//   clk        : clock
//   reset      : synchronous active-high reset
//   x          : serial command line (start bit, 3 data bits MSB first, [parity])
//   selsw      : applied switch-select code
//   sel_valid  : one-cycle pulse when selsw updates
//   frame_err  : one-cycle pulse when a frame fails parity
//   busy       : high whenever the controller is not idle (combinational)
//   err_cnt    : saturating count of rejected frames
module sw_sel_ctrl
  import sw_sel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  output logic [SEL_W-1:0]     selsw,
  output logic                 sel_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]       shift_q, shift_d;
  logic [SEL_W-1:0]       selsw_q, selsw_d;
  logic                   sel_valid_q, sel_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   hold_load;
  logic                   hold_done_c;

  sw_sel_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (hold_load),
    .done_c (hold_done_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    selsw_d     = selsw_q;
    sel_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    hold_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (x) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        shift_d   = {shift_q[SEL_W-2:0], x};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef SW_SEL_PARITY_EN
          state_d = ST_PARITY;
`else
          // Without parity the last data bit completes the frame.
          selsw_d     = {shift_q[SEL_W-2:0], x};
          sel_valid_d = 1'b1;
          hold_load   = 1'b1;
          state_d     = ST_HOLD;
`endif
        end
      end

      ST_PARITY: begin
`ifdef SW_SEL_PARITY_EN
        if (parity_even(shift_q, x)) begin
          selsw_d     = shift_q;
          sel_valid_d = 1'b1;
          hold_load   = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          frame_err_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_HOLD: begin
        // x is ignored for the whole dwell.
        if (hold_done_c) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All state; reset wins over any event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      selsw_q     <= '0;
      sel_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      selsw_q     <= selsw_d;
      sel_valid_q <= sel_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign selsw     = selsw_q;
  assign sel_valid = sel_valid_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sw_sel_ctrl.sv
// tb_sw_sel_ctrl: directed and randomized checks of sw_sel_ctrl against a
// frame-level reference model. Build with SW_SEL_PARITY_EN to test the parity variant.
module tb_sw_sel_ctrl;

  localparam int unsigned HOLD = 4;
`ifdef SW_SEL_PARITY_EN
  localparam int unsigned NBITS = 5;
`else
  localparam int unsigned NBITS = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic [2:0] selsw;
  logic       sel_valid;
  logic       frame_err;
  logic       busy;
  logic [3:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sw_sel_ctrl #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .selsw     (selsw),
    .sel_valid (sel_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: collects frame bits in a queue, decides at frame end.
  bit         m_in;
  bit         m_frame[$];
  int         m_hold;
  logic [2:0] m_sel;
  bit         m_valid;
  bit         m_err;
  int         m_cnt;

  task automatic model_step(input bit xv, input bit rv);
    int ones;
    bit ok;
    m_valid = 0;
    m_err   = 0;
    if (rv) begin
      m_in = 0; m_frame.delete(); m_hold = 0; m_sel = '0; m_cnt = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (!m_in) begin
      if (xv) begin
        m_in = 1;
        m_frame.delete();
      end
    end else begin
      m_frame.push_back(xv);
      if (m_frame.size() == NBITS - 1) begin
        ones = 0;
        foreach (m_frame[i]) ones += int'(m_frame[i]);
        ok = (NBITS == 4) ? 1'b1 : ((ones % 2) == 0);
        m_in = 0;
        if (ok) begin
          m_sel   = {m_frame[0], m_frame[1], m_frame[2]};
          m_valid = 1;
          m_hold  = HOLD;
        end else begin
          m_err = 1;
          if (m_cnt < 15) m_cnt++;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, settle past it.
  task automatic step(input bit xv, input bit rv);
    x     = xv;
    reset = rv;
    @(posedge clk);
    model_step(xv, rv);
    #1;
  endtask

  task automatic test_reset();
    step(0, 1);
    step(0, 1);
    n_cmp++;
    if ({selsw, sel_valid, frame_err, busy, err_cnt} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", {selsw, sel_valid, frame_err, busy, err_cnt}, 10'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      n_cmp++;
      if ({selsw, sel_valid, frame_err, busy, err_cnt} !== 10'b0) begin
        n_bad++;
        $display("FAIL idle_quiet[%0d]: got %b want %b", i, {selsw, sel_valid, frame_err, busy, err_cnt}, 10'b0);
      end
    end
  endtask

  task automatic test_valid_frame();
    bit         seq[$];
    logic [2:0] want;
    int         busy_n;
`ifdef SW_SEL_PARITY_EN
    seq  = '{1, 1, 0, 1, 0};
    want = 3'b101;
`else
    seq  = '{1, 0, 1, 0};
    want = 3'b010;
`endif
    busy_n = 0;
    foreach (seq[i]) begin
      step(seq[i], 0);
      if (busy) busy_n++;
      if (i < seq.size() - 1) begin
        n_cmp++;
        if (sel_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL early_valid[%0d]: got %b want 0", i, sel_valid);
        end
      end
    end
    n_cmp++;
    if ({selsw, sel_valid, frame_err} !== {want, 2'b10}) begin
      n_bad++;
      $display("FAIL accept: got sel=%b v=%b e=%b want sel=%b v=1 e=0", selsw, sel_valid, frame_err, want);
    end
    for (int i = 0; i < 40 && busy; i++) begin
      step(0, 0);
      if (busy) busy_n++;
      if (i == 0) begin
        n_cmp++;
        if (sel_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL valid_pulse_width: got %b want 0", sel_valid);
        end
      end
    end
    n_cmp++;
    if (busy_n != int'(NBITS - 1 + HOLD) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_len: got %0d (busy=%b) want %0d", busy_n, busy, NBITS - 1 + HOLD);
    end
  endtask

`ifdef SW_SEL_PARITY_EN
  task automatic test_bad_parity();
    bit seq[$];
    seq = '{1, 0, 1, 1, 1};
    foreach (seq[i]) step(seq[i], 0);
    n_cmp++;
    if ({selsw, sel_valid, frame_err, busy, err_cnt} !== {3'b101, 3'b010, 4'd1}) begin
      n_bad++;
      $display("FAIL bad_parity: got %b want %b", {selsw, sel_valid, frame_err, busy, err_cnt}, {3'b101, 3'b010, 4'd1});
    end
    step(0, 0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse_width: got %b want 0", frame_err);
    end
    for (int f = 0; f < 16; f++) foreach (seq[i]) step(seq[i], 0);
    n_cmp++;
    if (err_cnt !== 4'd15 || selsw !== 3'b101) begin
      n_bad++;
      $display("FAIL err_saturate: got cnt=%0d sel=%b want cnt=15 sel=101", err_cnt, selsw);
    end
  endtask
`else
  task automatic test_no_parity_frame();
    bit seq[$];
    seq = '{1, 0, 1, 1};
    foreach (seq[i]) step(seq[i], 0);
    n_cmp++;
    if ({selsw, sel_valid, frame_err, err_cnt} !== {3'b011, 2'b10, 4'd0}) begin
      n_bad++;
      $display("FAIL no_parity_accept: got %b want %b", {selsw, sel_valid, frame_err, err_cnt}, {3'b011, 2'b10, 4'd0});
    end
    for (int i = 0; i < HOLD; i++) step(0, 0);
  endtask
`endif

  task automatic test_hold_ignore();
    bit seq[$];
    bit tail[$];
`ifdef SW_SEL_PARITY_EN
    seq  = '{1, 1, 1, 0, 0};
    tail = '{0, 0, 1, 1};
`else
    seq  = '{1, 1, 1, 0};
    tail = '{0, 0, 1};
`endif
    foreach (seq[i]) step(seq[i], 0);
    n_cmp++;
    if (selsw !== 3'b110 || sel_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_frame: got sel=%b v=%b want sel=110 v=1", selsw, sel_valid);
    end
    for (int i = 1; i <= HOLD; i++) begin
      step(1, 0);
      n_cmp++;
      if (busy !== (i < HOLD) || sel_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_busy[%0d]: got busy=%b v=%b want busy=%b v=0", i, busy, sel_valid, i < HOLD);
      end
    end
    step(1, 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back_start: got busy=%b want 1", busy);
    end
    foreach (tail[i]) step(tail[i], 0);
    n_cmp++;
    if (selsw !== 3'b001 || sel_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back_frame: got sel=%b v=%b want sel=001 v=1", selsw, sel_valid);
    end
    for (int i = 0; i < HOLD; i++) step(0, 0);
  endtask

  task automatic test_reset_midframe();
    step(0, 1);
    step(1, 0);
    step(1, 0);
    step(1, 0);
    step(1, 1);
    n_cmp++;
    if ({selsw, sel_valid, frame_err, busy} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_midframe: got %b want %b", {selsw, sel_valid, frame_err, busy}, 6'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      n_cmp++;
      if ({selsw, sel_valid, frame_err, busy} !== 6'b0) begin
        n_bad++;
        $display("FAIL after_reset_midframe[%0d]: got %b want 0", i, {selsw, sel_valid, frame_err, busy});
      end
    end
    // Reset during the dwell.
    step(1, 0); step(1, 0); step(0, 0); step(1, 0);
`ifdef SW_SEL_PARITY_EN
    step(0, 0);
`endif
    step(0, 0);
    step(0, 1);
    n_cmp++;
    if ({selsw, sel_valid, frame_err, busy} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_midhold: got %b want %b", {selsw, sel_valid, frame_err, busy}, 6'b0);
    end
  endtask

  task automatic test_random();
    bit xv, rv;
    int n_valid;
    n_valid = 0;
    step(0, 1);
    for (int i = 0; i < 3000; i++) begin
      xv = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 99) == 0);
      step(xv, rv);
      if (sel_valid) n_valid++;
      n_cmp++;
      if ({selsw, sel_valid, frame_err, busy, err_cnt} !==
          {m_sel, m_valid, m_err, (m_in || m_hold > 0), 4'(m_cnt)}) begin
        n_bad++;
        $display("FAIL random[%0d]: got %b want %b", i, {selsw, sel_valid, frame_err, busy, err_cnt},
                 {m_sel, m_valid, m_err, (m_in || m_hold > 0), 4'(m_cnt)});
      end
      n_cmp++;
      if (sel_valid && frame_err) begin
        n_bad++;
        $display("FAIL pulse_exclusive[%0d]: got v=%b e=%b want not both", i, sel_valid, frame_err);
      end
    end
    n_cmp++;
    if (n_valid == 0) begin
      n_bad++;
      $display("FAIL random_activity: got %0d accepts want >0", n_valid);
    end
  endtask

  initial begin
    x     = 1'b0;
    reset = 1'b1;
    test_reset();
    test_valid_frame();
`ifdef SW_SEL_PARITY_EN
    test_bad_parity();
`else
    test_no_parity_frame();
`endif
    test_hold_ignore();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
